// File: rtl/pif_ram_arbiter_pkg.sv
// Shared types and constants for the PIF RAM arbiter: host FSM states,
// grant-owner encoding and big-endian byte-lane helpers.
package pif_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } host_state_e;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_IDX       = 2'(BYTES_PER_WORD - 1);

  // Byte lane 0 is the most significant byte of the host word.
  function automatic logic [7:0] word_lane(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      2'd3:    b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] set_lane(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      2'd3:    r[7:0]   = b;
      default: r        = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pif_ram_arbiter_rr_arb.sv
// Two-way round-robin picker between the 6502 CPU and the host burst engine.
// Under contention the requester that did not win the previous slot is chosen.
module pif_ram_rr_arb
  import pif_ram_arb_pkg::*;
(
  input  logic req_cpu,
  input  logic req_host,
  input  logic rr_last,
  output logic grant_cpu,
  output logic grant_host
);

  // Select one winner per cycle; uncontended requests pass straight through
  always_comb begin
    grant_cpu  = 1'b0;
    grant_host = 1'b0;
    if (req_cpu && req_host) begin
      if (rr_last == OWN_HOST) begin
        grant_cpu = 1'b1;
      end else begin
        grant_host = 1'b1;
      end
    end else begin
      grant_cpu  = req_cpu;
      grant_host = req_host;
    end
  end

endmodule

// File: rtl/pif_ram_arbiter.sv
// Shares the single-port 512x8 PIF RAM between 6502 byte accesses and host word bursts.
// Optional build macro PIF_ARB_CONFLICT_CNT_EN adds the conflict_cnt output.
module pif_ram_arbiter
  import pif_ram_arb_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int HOST_AW = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [HOST_AW-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_busy,
  output logic              host_done,
  output logic [31:0]       host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  output logic              ram_oe,
  input  logic              ram_valid,
  input  logic [7:0]        ram_q
`ifdef PIF_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  host_state_e        state_r;
  host_state_e        state_s;
  logic [HOST_AW-1:0] addr_r;
  logic               we_r;
  logic [31:0]        wdata_r;
  logic [1:0]         idx_r;
  logic               rr_last_r;
  logic               pend_r;
  logic               tag_r;
  logic [1:0]         lane_r;
  logic [31:0]        rbuf_r;
  logic [31:0]        host_rdata_r;

  logic req_cpu_s;
  logic req_host_s;
  logic grant_cpu_s;
  logic grant_host_s;
  logic rvalid_s;
  logic host_lane_s;

  // Reset also blanks requests so nothing reaches the RAM during the reset cycle
  assign req_cpu_s  = cpu_req & ~reset;
  assign req_host_s = (state_r == BURST) & ~reset;

  pif_ram_rr_arb u_rr_arb (
    .req_cpu    (req_cpu_s),
    .req_host   (req_host_s),
    .rr_last    (rr_last_r),
    .grant_cpu  (grant_cpu_s),
    .grant_host (grant_host_s)
  );

  // Drive the RAM port from whichever side owns this slot
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_oe    = 1'b0;
    ram_wdata = 8'h00;
    if (grant_host_s) begin
      ram_addr  = ADDR_W'({addr_r, idx_r});
      ram_we    = we_r;
      ram_oe    = ~we_r;
      ram_wdata = we_r ? word_lane(wdata_r, idx_r) : 8'h00;
    end else if (grant_cpu_s) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_oe    = ~cpu_we;
      ram_wdata = cpu_we ? cpu_wdata : 8'h00;
    end else begin
      ram_addr = '0;
    end
  end

  // pend_r filters out a stray valid that was in flight when reset hit
  assign rvalid_s    = ram_valid & pend_r;
  assign cpu_rvalid  = rvalid_s & (tag_r == OWN_CPU);
  assign cpu_rdata   = cpu_rvalid ? ram_q : 8'h00;
  assign host_lane_s = rvalid_s & (tag_r == OWN_HOST);
  assign cpu_ack     = grant_cpu_s;
  assign host_busy   = (state_r != IDLE);
  assign host_done   = (state_r == DONE);
  assign host_rdata  = host_rdata_r;

  // Host burst sequencing: one word becomes four byte slots
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (host_req) begin
          state_s = BURST;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (grant_host_s && (idx_r == LAST_IDX)) begin
          state_s = we_r ? DONE : WAIT;
        end else begin
          state_s = BURST;
        end
      end
      WAIT: begin
        if (host_lane_s && (lane_r == LAST_IDX)) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state and captured host request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      addr_r  <= '0;
      we_r    <= 1'b0;
      wdata_r <= 32'h0000_0000;
      idx_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && host_req) begin
        addr_r  <= host_addr;
        we_r    <= host_we;
        wdata_r <= host_wdata;
        idx_r   <= 2'd0;
      end else if (grant_host_s) begin
        idx_r <= idx_r + 2'd1;
      end
    end
  end

  // Round-robin history and read-owner tag for the one outstanding RAM read
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_r <= OWN_HOST;
      pend_r    <= 1'b0;
      tag_r     <= OWN_CPU;
      lane_r    <= 2'd0;
    end else begin
      if (grant_cpu_s || grant_host_s) begin
        rr_last_r <= grant_host_s ? OWN_HOST : OWN_CPU;
      end
      pend_r <= ram_oe;
      tag_r  <= grant_host_s ? OWN_HOST : OWN_CPU;
      lane_r <= idx_r;
    end
  end

  // Assemble host read bytes; publish the word only once the last lane lands
  always_ff @(posedge clk) begin
    if (reset) begin
      rbuf_r       <= 32'h0000_0000;
      host_rdata_r <= 32'h0000_0000;
    end else begin
      if (host_lane_s) begin
        rbuf_r <= set_lane(rbuf_r, lane_r, ram_q);
      end
      if (host_lane_s && (lane_r == LAST_IDX)) begin
        host_rdata_r <= set_lane(rbuf_r, lane_r, ram_q);
      end
    end
  end

`ifdef PIF_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_r;

  // Count contended slots lost by the host, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_r <= 16'h0000;
    end else if (req_cpu_s && req_host_s && grant_cpu_s && (conflict_cnt_r != 16'hFFFF)) begin
      conflict_cnt_r <= conflict_cnt_r + 16'h0001;
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign conflict_cnt = conflict_cnt_r;
`endif

endmodule
